// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage PMIPSL datapath: PC mux select, pipeline hold/flush strobes, debug halt/step.
// Zero-cycle latency (outputs combinational from state and inputs); stalls issue on load-use, squashes on redirect.
module pipe_hazard_ctrl #(
   parameter int INIT_CYCLES  = 4,
   parameter int CNT_W        = 16,
   parameter bit R0_HARDWIRED = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [2:0]       id_rs1,
   input  logic [2:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic             ex_memread,
   input  logic             ex_regwrite,
   input  logic [2:0]       ex_waddr,
   input  logic             mem_taken,
   input  logic             mem_jump,
   input  logic             halt_req,
   input  logic             step,
   output logic [1:0]       pc_control,
   output logic             ifid_hold,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);

   localparam logic [1:0] PC_HOLD  = 2'd0;
   localparam logic [1:0] PC_INC   = 2'd1;
   localparam logic [1:0] PC_REDIR = 2'd2;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_RUN,
      ST_HALT,
      ST_STEP
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    init_q, init_d;
   logic [CNT_W-1:0] stall_q, flush_q;
   logic             luse, luse_raw, redir;
   logic             stall_inc, flush_inc;

   // Load-use: the load in EX writes a register the ID instruction reads.
   always_comb begin
      luse_raw = ex_memread & ex_regwrite &
                 ((ex_waddr == id_rs1) | (id_uses_rs2 & (ex_waddr == id_rs2)));
      luse     = luse_raw & ~(R0_HARDWIRED & (ex_waddr == 3'd0));
      redir    = mem_taken | mem_jump;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_INIT;
         init_q  <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         init_q  <= init_d;
         if (stall_inc && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
         if (flush_inc && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      init_d      = init_q;
      pc_control  = PC_INC;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      halted      = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;

      if (reset) begin
         pc_control  = PC_HOLD;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else begin
         unique case (state_q)
            ST_INIT: begin
               pc_control  = PC_HOLD;
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
               init_d      = init_q + IW'(1);
               if (init_q == INIT_LAST) state_d = ST_RUN;
            end

            ST_RUN, ST_STEP: begin
               if (redir) begin
                  pc_control  = PC_REDIR;
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  flush_inc   = 1'b1;
                  // A pending halt is re-evaluated next cycle; a step is consumed.
                  if (state_q == ST_STEP) state_d = ST_HALT;
               end else if (luse) begin
                  pc_control = PC_HOLD;
                  ifid_hold  = 1'b1;
                  idex_flush = 1'b1;
                  stall_inc  = 1'b1;
               end else if (state_q == ST_STEP) begin
                  state_d = ST_HALT;
               end else if (halt_req) begin
                  state_d = ST_HALT;
               end
            end

            ST_HALT: begin
               halted = 1'b1;
               if (redir) begin
                  pc_control  = PC_REDIR;
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  flush_inc   = 1'b1;
               end else begin
                  pc_control = PC_HOLD;
                  ifid_hold  = 1'b1;
                  idex_flush = 1'b1;
                  if (!halt_req) state_d = ST_RUN;
                  else if (step) state_d = ST_STEP;
               end
            end

            default: state_d = ST_INIT;
         endcase
      end
   end

   assign stall_count = stall_q;
   assign flush_count = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset/init, load-use, redirect, halt/step, counter saturation.
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 16;

   localparam logic [6:0] V_INIT   = 7'b00_0_111_0;
   localparam logic [6:0] V_RUN    = 7'b01_0_000_0;
   localparam logic [6:0] V_STALL  = 7'b00_1_010_0;
   localparam logic [6:0] V_REDIR  = 7'b10_0_111_0;
   localparam logic [6:0] V_HALT   = 7'b00_1_010_1;
   localparam logic [6:0] V_HREDIR = 7'b10_0_111_1;

   logic             clock = 1'b0;
   logic             reset;
   logic [2:0]       id_rs1, id_rs2, ex_waddr;
   logic             id_uses_rs2, ex_memread, ex_regwrite;
   logic             mem_taken, mem_jump, halt_req, step;
   logic [1:0]       pc_control;
   logic             ifid_hold, ifid_flush, idex_flush, exmem_flush, halted;
   logic [CNT_W-1:0] stall_count, flush_count;
   logic [6:0]       obs;

   int tests = 0;
   int fails = 0;

   pipe_hazard_ctrl #(.INIT_CYCLES(4), .CNT_W(CNT_W), .R0_HARDWIRED(1'b1)) dut (
      .clock       (clock),
      .reset       (reset),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs2 (id_uses_rs2),
      .ex_memread  (ex_memread),
      .ex_regwrite (ex_regwrite),
      .ex_waddr    (ex_waddr),
      .mem_taken   (mem_taken),
      .mem_jump    (mem_jump),
      .halt_req    (halt_req),
      .step        (step),
      .pc_control  (pc_control),
      .ifid_hold   (ifid_hold),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .exmem_flush (exmem_flush),
      .halted      (halted),
      .stall_count (stall_count),
      .flush_count (flush_count)
   );

   always #5 clock = ~clock;

   assign obs = {pc_control, ifid_hold, ifid_flush, idex_flush, exmem_flush, halted};

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      id_rs1 = 3'd1; id_rs2 = 3'd2; id_uses_rs2 = 1'b0;
      ex_memread = 1'b0; ex_regwrite = 1'b0; ex_waddr = 3'd7;
      mem_taken = 1'b0; mem_jump = 1'b0; halt_req = 1'b0; step = 1'b0;
   endtask

   task automatic set_load(input logic [2:0] wa, input logic [2:0] r1,
                           input logic [2:0] r2, input logic use2);
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_waddr = wa;
      id_rs1 = r1; id_rs2 = r2; id_uses_rs2 = use2;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      cycle(); cycle();
      tests++; if (obs !== V_INIT) begin fails++; $display("FAIL reset_outputs: got %b expected %b", obs, V_INIT); end
      tests++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
         fails++; $display("FAIL reset_counters: got %h/%h expected 0000/0000", stall_count, flush_count); end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests++; if (obs !== V_INIT) begin fails++; $display("FAIL init_cycle%0d: got %b expected %b", i, obs, V_INIT); end
         cycle();
      end
      tests++; if (obs !== V_RUN) begin fails++; $display("FAIL init_to_run: got %b expected %b", obs, V_RUN); end
   endtask

   task automatic test_load_use();
      set_load(3'd3, 3'd3, 3'd2, 1'b0);
      #1;
      tests++; if (obs !== V_STALL) begin fails++; $display("FAIL luse_rs1: got %b expected %b", obs, V_STALL); end
      cycle();
      idle(); #1;
      tests++; if (obs !== V_RUN) begin fails++; $display("FAIL luse_release: got %b expected %b", obs, V_RUN); end
      tests++; if (stall_count !== 16'd1) begin fails++; $display("FAIL luse_count1: got %0d expected 1", stall_count); end
      set_load(3'd0, 3'd0, 3'd2, 1'b0);
      #1;
      tests++; if (obs !== V_RUN) begin fails++; $display("FAIL luse_r0: got %b expected %b", obs, V_RUN); end
      cycle();
      set_load(3'd5, 3'd1, 3'd5, 1'b1);
      #1;
      tests++; if (obs !== V_STALL) begin fails++; $display("FAIL luse_rs2: got %b expected %b", obs, V_STALL); end
      cycle();
      set_load(3'd5, 3'd1, 3'd5, 1'b0);
      #1;
      tests++; if (obs !== V_RUN) begin fails++; $display("FAIL luse_rs2_unused: got %b expected %b", obs, V_RUN); end
      cycle();
      idle(); #1;
      tests++; if (stall_count !== 16'd2) begin fails++; $display("FAIL luse_count2: got %0d expected 2", stall_count); end
   endtask

   task automatic test_redirect();
      set_load(3'd3, 3'd3, 3'd2, 1'b0);
      mem_taken = 1'b1;
      #1;
      tests++; if (obs !== V_REDIR) begin fails++; $display("FAIL redir_over_luse: got %b expected %b", obs, V_REDIR); end
      cycle();
      idle(); #1;
      tests++; if (flush_count !== 16'd1) begin fails++; $display("FAIL redir_flush_count: got %0d expected 1", flush_count); end
      tests++; if (stall_count !== 16'd2) begin fails++; $display("FAIL redir_stall_count: got %0d expected 2", stall_count); end
   endtask

   task automatic test_halt_step();
      halt_req = 1'b1; #1;
      tests++; if (obs !== V_RUN) begin fails++; $display("FAIL halt_req_cycle: got %b expected %b", obs, V_RUN); end
      cycle();
      tests++; if (obs !== V_HALT) begin fails++; $display("FAIL halt_entry: got %b expected %b", obs, V_HALT); end
      step = 1'b1; #1;
      tests++; if (obs !== V_HALT) begin fails++; $display("FAIL step_request: got %b expected %b", obs, V_HALT); end
      cycle();
      step = 1'b0; #1;
      tests++; if (obs !== V_RUN) begin fails++; $display("FAIL step_issue: got %b expected %b", obs, V_RUN); end
      cycle();
      tests++; if (obs !== V_HALT) begin fails++; $display("FAIL step_rehalt: got %b expected %b", obs, V_HALT); end
      // Step that hits a load-use stall must wait for the instruction to issue.
      step = 1'b1; cycle(); step = 1'b0;
      set_load(3'd4, 3'd4, 3'd2, 1'b0); #1;
      tests++; if (obs !== V_STALL) begin fails++; $display("FAIL step_stall: got %b expected %b", obs, V_STALL); end
      cycle();
      idle(); halt_req = 1'b1; #1;
      tests++; if (obs !== V_RUN) begin fails++; $display("FAIL step_after_stall: got %b expected %b", obs, V_RUN); end
      cycle();
      tests++; if (obs !== V_HALT) begin fails++; $display("FAIL step_stall_rehalt: got %b expected %b", obs, V_HALT); end
      tests++; if (stall_count !== 16'd3) begin fails++; $display("FAIL step_stall_count: got %0d expected 3", stall_count); end
      mem_taken = 1'b1; #1;
      tests++; if (obs !== V_HREDIR) begin fails++; $display("FAIL halt_redir: got %b expected %b", obs, V_HREDIR); end
      cycle();
      mem_taken = 1'b0; #1;
      tests++; if (obs !== V_HALT) begin fails++; $display("FAIL halt_after_redir: got %b expected %b", obs, V_HALT); end
      tests++; if (flush_count !== 16'd2) begin fails++; $display("FAIL halt_flush_count: got %0d expected 2", flush_count); end
      halt_req = 1'b0; #1;
      tests++; if (obs !== V_HALT) begin fails++; $display("FAIL halt_release_cycle: got %b expected %b", obs, V_HALT); end
      cycle();
      tests++; if (obs !== V_RUN) begin fails++; $display("FAIL halt_to_run: got %b expected %b", obs, V_RUN); end
   endtask

   task automatic test_halt_redirect();
      halt_req = 1'b1; mem_jump = 1'b1; #1;
      tests++; if (obs !== V_REDIR) begin fails++; $display("FAIL halt_jump_redir: got %b expected %b", obs, V_REDIR); end
      cycle();
      mem_jump = 1'b0; #1;
      tests++; if (obs !== V_RUN) begin fails++; $display("FAIL halt_deferred: got %b expected %b", obs, V_RUN); end
      cycle();
      tests++; if (obs !== V_HALT) begin fails++; $display("FAIL halt_after_defer: got %b expected %b", obs, V_HALT); end
      tests++; if (flush_count !== 16'd3) begin fails++; $display("FAIL jump_flush_count: got %0d expected 3", flush_count); end
      halt_req = 1'b0;
      cycle();
      tests++; if (obs !== V_RUN) begin fails++; $display("FAIL defer_to_run: got %b expected %b", obs, V_RUN); end
   endtask

   task automatic test_saturation();
      mem_taken = 1'b1;
      for (int i = 0; i < 65536 + 3; i++) cycle();
      mem_taken = 1'b0; #1;
      tests++; if (flush_count !== 16'hFFFF) begin fails++; $display("FAIL flush_saturate: got %h expected ffff", flush_count); end
      tests++; if (stall_count !== 16'd3) begin fails++; $display("FAIL sat_stall_count: got %0d expected 3", stall_count); end
      set_load(3'd6, 3'd6, 3'd2, 1'b0); #1;
      tests++; if (obs !== V_STALL) begin fails++; $display("FAIL pre_reset_stall: got %b expected %b", obs, V_STALL); end
      reset = 1'b1; #1;
      tests++; if (obs !== V_INIT) begin fails++; $display("FAIL reset_mid_stall: got %b expected %b", obs, V_INIT); end
      cycle();
      tests++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
         fails++; $display("FAIL reset_clears: got %h/%h expected 0000/0000", stall_count, flush_count); end
      reset = 1'b0; idle(); #1;
      tests++; if (obs !== V_INIT) begin fails++; $display("FAIL reinit: got %b expected %b", obs, V_INIT); end
      for (int i = 0; i < 4; i++) cycle();
      tests++; if (obs !== V_RUN) begin fails++; $display("FAIL reinit_to_run: got %b expected %b", obs, V_RUN); end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_load_use();
      test_redirect();
      test_halt_step();
      test_halt_redirect();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
